// File: rtl/timepulse_gen.sv
// Timepulse generator: twelve time pulses of four phases each form one 48-clock memory cycle.
// Monitor stop/start can park the sequencer between cycles; GOJAM forces a restart at T01.
module timepulse_gen (
    input  logic CLOCK,
    input  logic rst,
    input  logic GOJAM,
    input  logic MSTP,
    input  logic MSTRT,
    output logic T01,
    output logic T02,
    output logic T03,
    output logic T04,
    output logic T05,
    output logic T06,
    output logic T07,
    output logic T08,
    output logic T09,
    output logic T10,
    output logic T11,
    output logic T12,
    output logic T01_,
    output logic T02_,
    output logic T03_,
    output logic T04_,
    output logic T05_,
    output logic T06_,
    output logic T07_,
    output logic T08_,
    output logic T09_,
    output logic T10_,
    output logic T11_,
    output logic T12_,
    output logic PHS2,
    output logic PHS3,
    output logic PHS4,
    output logic PHS2_,
    output logic PHS3_,
    output logic PHS4_,
    output logic MCTEND,
    output logic HALTED
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } state_e;

    localparam logic [3:0] TP_FIRST = 4'd1;
    localparam logic [3:0] TP_LAST  = 4'd12;
    // Phase is stored as ph-1, so 2'd0 is ph 1 and 2'd3 is ph 4.
    localparam logic [1:0] PH_FIRST = 2'd0;
    localparam logic [1:0] PH_LAST  = 2'd3;

    state_e      state_q, state_d;
    logic [3:0]  tp_q, tp_d;
    logic [1:0]  ph_q, ph_d;
    logic        mstrt_q, mstrt_prev_q;
    logic        mstrt_rise;

    logic [12:1] t_q, t_d;
    logic [4:2]  phs_q, phs_d;
    logic        mctend_q, mctend_d;
    logic        halted_q, halted_d;

    assign mstrt_rise = mstrt_q & ~mstrt_prev_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d = state_q;
        tp_d    = tp_q;
        ph_d    = ph_q;
        if (GOJAM) begin
            state_d = ST_RUN;
            tp_d    = TP_FIRST;
            ph_d    = PH_FIRST;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    tp_d    = TP_FIRST;
                    ph_d    = PH_FIRST;
                end
                ST_RUN: begin
                    if (ph_q != PH_LAST) begin
                        ph_d = ph_q + 2'd1;
                    end else if (tp_q != TP_LAST) begin
                        tp_d = tp_q + 4'd1;
                        ph_d = PH_FIRST;
                    end else if (MSTP) begin
                        // MSTP only matters here, so a mid-cycle stop always finishes the cycle.
                        state_d = ST_HOLD;
                    end else begin
                        tp_d = TP_FIRST;
                        ph_d = PH_FIRST;
                    end
                end
                ST_HOLD: begin
                    if (mstrt_rise || !MSTP) begin
                        state_d = ST_RUN;
                        tp_d    = TP_FIRST;
                        ph_d    = PH_FIRST;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so every pin is a flop (or its inverse).
    always_comb begin
        t_d      = '0;
        phs_d    = '0;
        halted_d = (state_d == ST_HOLD);
        if (state_d == ST_RUN) begin
            for (int i = 1; i <= 12; i++) begin
                t_d[i] = (tp_d == 4'(i));
            end
            case (ph_d)
                2'd1:    phs_d[2] = 1'b1;
                2'd2:    phs_d[3] = 1'b1;
                2'd3:    phs_d[4] = 1'b1;
                default: phs_d    = '0;
            endcase
        end
        mctend_d = t_d[12] & phs_d[4];
    end

    // NOTE: sequential state uses non-blocking assignments only, and every flop here is reset
    // asynchronously so the outputs drop the instant rst rises, without waiting for a clock.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tp_q         <= TP_FIRST;
            ph_q         <= PH_FIRST;
            mstrt_q      <= 1'b0;
            mstrt_prev_q <= 1'b0;
            t_q          <= '0;
            phs_q        <= '0;
            mctend_q     <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            tp_q         <= tp_d;
            ph_q         <= ph_d;
            mstrt_q      <= MSTRT;
            mstrt_prev_q <= mstrt_q;
            t_q          <= t_d;
            phs_q        <= phs_d;
            mctend_q     <= mctend_d;
            halted_q     <= halted_d;
        end
    end

    assign T01 = t_q[1];
    assign T02 = t_q[2];
    assign T03 = t_q[3];
    assign T04 = t_q[4];
    assign T05 = t_q[5];
    assign T06 = t_q[6];
    assign T07 = t_q[7];
    assign T08 = t_q[8];
    assign T09 = t_q[9];
    assign T10 = t_q[10];
    assign T11 = t_q[11];
    assign T12 = t_q[12];

    assign T01_ = ~t_q[1];
    assign T02_ = ~t_q[2];
    assign T03_ = ~t_q[3];
    assign T04_ = ~t_q[4];
    assign T05_ = ~t_q[5];
    assign T06_ = ~t_q[6];
    assign T07_ = ~t_q[7];
    assign T08_ = ~t_q[8];
    assign T09_ = ~t_q[9];
    assign T10_ = ~t_q[10];
    assign T11_ = ~t_q[11];
    assign T12_ = ~t_q[12];

    assign PHS2   = phs_q[2];
    assign PHS3   = phs_q[3];
    assign PHS4   = phs_q[4];
    assign PHS2_  = ~phs_q[2];
    assign PHS3_  = ~phs_q[3];
    assign PHS4_  = ~phs_q[4];
    assign MCTEND = mctend_q;
    assign HALTED = halted_q;

    a_run_onehot : assert property (@(posedge CLOCK) disable iff (rst)
        (state_q == ST_RUN) |-> $onehot(t_q));
    a_parked_quiet : assert property (@(posedge CLOCK) disable iff (rst)
        (state_q != ST_RUN) |-> (t_q == '0 && phs_q == '0 && !mctend_q));

endmodule

// File: tb/tb_timepulse_gen.sv
// Self-checking bench for timepulse_gen: randomized stimulus against a position-in-cycle reference model.
module tb_timepulse_gen;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_HOLD    = 2;
    localparam int CYCLE_LEN = 48;

    logic CLOCK, rst, GOJAM, MSTP, MSTRT;
    logic T01, T02, T03, T04, T05, T06, T07, T08, T09, T10, T11, T12;
    logic T01_, T02_, T03_, T04_, T05_, T06_, T07_, T08_, T09_, T10_, T11_, T12_;
    logic PHS2, PHS3, PHS4, PHS2_, PHS3_, PHS4_, MCTEND, HALTED;

    logic [11:0] dut_t, dut_tn;
    logic [31:0] dut_vec;

    int checks = 0;
    int passes = 0;

    // Reference model: mode plus flat position 0..47 within the memory cycle.
    int m_mode = M_IDLE;
    int m_pos  = 0;
    bit m_s1   = 1'b0;
    bit m_s2   = 1'b0;

    timepulse_gen dut (
        .CLOCK(CLOCK), .rst(rst), .GOJAM(GOJAM), .MSTP(MSTP), .MSTRT(MSTRT),
        .T01(T01), .T02(T02), .T03(T03), .T04(T04), .T05(T05), .T06(T06),
        .T07(T07), .T08(T08), .T09(T09), .T10(T10), .T11(T11), .T12(T12),
        .T01_(T01_), .T02_(T02_), .T03_(T03_), .T04_(T04_), .T05_(T05_), .T06_(T06_),
        .T07_(T07_), .T08_(T08_), .T09_(T09_), .T10_(T10_), .T11_(T11_), .T12_(T12_),
        .PHS2(PHS2), .PHS3(PHS3), .PHS4(PHS4),
        .PHS2_(PHS2_), .PHS3_(PHS3_), .PHS4_(PHS4_),
        .MCTEND(MCTEND), .HALTED(HALTED)
    );

    assign dut_t   = {T12, T11, T10, T09, T08, T07, T06, T05, T04, T03, T02, T01};
    assign dut_tn  = {T12_, T11_, T10_, T09_, T08_, T07_, T06_, T05_, T04_, T03_, T02_, T01_};
    assign dut_vec = {dut_t, dut_tn, PHS4, PHS3, PHS2, PHS4_, PHS3_, PHS2_, MCTEND, HALTED};

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pos  = 0;
        m_s1   = 1'b0;
        m_s2   = 1'b0;
    endtask

    task automatic model_step();
        bit rise;
        rise = m_s1 && !m_s2;
        if (GOJAM) begin
            m_mode = M_RUN;
            m_pos  = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_RUN;
            m_pos  = 0;
        end else if (m_mode == M_RUN) begin
            if (m_pos == CYCLE_LEN - 1) begin
                m_pos = 0;
                if (MSTP) m_mode = M_HOLD;
            end else begin
                m_pos++;
            end
        end else if (rise || !MSTP) begin
            m_mode = M_RUN;
            m_pos  = 0;
        end
        m_s2 = m_s1;
        m_s1 = MSTRT;
    endtask

    function automatic logic [31:0] exp_vec();
        logic [11:0] t;
        logic [2:0]  p;
        int          ph;
        t  = '0;
        p  = '0;
        ph = m_pos % 4 + 1;
        if (m_mode == M_RUN) begin
            t[m_pos / 4] = 1'b1;
            if (ph >= 2) p[ph - 2] = 1'b1;
        end
        return {t, ~t, p, ~p, (m_mode == M_RUN && m_pos == CYCLE_LEN - 1), (m_mode == M_HOLD)};
    endfunction

    // One rising edge, model update, then settle 1 time unit past the edge.
    task automatic tick();
        @(posedge CLOCK);
        if (rst) model_reset();
        else     model_step();
        #1;
    endtask

    task automatic advance_to(input int pos);
        int n;
        n = 0;
        while (!(m_mode == M_RUN && m_pos == pos) && n < 200) begin
            tick();
            n++;
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL advance pos=%0d dut=%h exp=%h", m_pos, dut_vec, exp_vec());
            else passes++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL advance_timeout target=%0d mode=%0d", pos, m_mode);
        end
    endtask

    task automatic run_to_hold(output int n);
        n = 0;
        while (m_mode != M_HOLD && n < 100) begin
            tick();
            n++;
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL to_hold n=%0d dut=%h exp=%h", n, dut_vec, exp_vec());
            else passes++;
        end
        if (n >= 100) begin
            checks++;
            $display("FAIL to_hold_timeout mode=%0d", m_mode);
        end
    endtask

    task automatic test_reset();
        GOJAM = 1'b0; MSTP = 1'b0; MSTRT = 1'b0; rst = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== {12'h000, 12'hFFF, 3'b000, 3'b111, 1'b0, 1'b0})
            $display("FAIL reset_async dut=%h exp=%h", dut_vec, exp_vec());
        else passes++;
        for (int i = 0; i < 3; i++) begin
            GOJAM = 1'($urandom); MSTP = 1'($urandom); MSTRT = 1'($urandom);
            tick();
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL reset_held i=%0d dut=%h exp=%h", i, dut_vec, exp_vec());
            else passes++;
        end
        GOJAM = 1'b0; MSTP = 1'b0; MSTRT = 1'b0;
    endtask

    task automatic test_first_cycle();
        logic [6:0] got, want;
        rst = 1'b0;
        for (int n = 1; n <= 49; n++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL first_cycle n=%0d dut=%h exp=%h", n, dut_vec, exp_vec());
            else passes++;
            if (n == 1 || n == 2 || n == 5 || n == 48 || n == 49) begin
                got = {T01, T02, T12, PHS2, PHS3, PHS4, MCTEND};
                case (n)
                    1:       want = 7'b1000000;
                    2:       want = 7'b1001000;
                    5:       want = 7'b0100000;
                    48:      want = 7'b0010011;
                    default: want = 7'b1000000;
                endcase
                checks++;
                if (got !== want) $display("FAIL first_cycle_spot n=%0d got=%b want=%b", n, got, want);
                else passes++;
            end
        end
    endtask

    task automatic test_free_run();
        int mct;
        mct = 0;
        repeat (10 * CYCLE_LEN) begin
            MSTRT = 1'($urandom);
            tick();
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL free_run pos=%0d dut=%h exp=%h", m_pos, dut_vec, exp_vec());
            else passes++;
            if (MCTEND === 1'b1) mct++;
        end
        checks++;
        if (mct !== 10) $display("FAIL free_run_mctend count=%0d want=10", mct);
        else passes++;
        MSTRT = 1'b0;
    endtask

    task automatic test_halt();
        int n;
        advance_to(16);
        MSTP = 1'b1;
        run_to_hold(n);
        checks++;
        if (HALTED !== 1'b1 || dut_t !== 12'h000) $display("FAIL halt_enter halted=%b t=%h", HALTED, dut_t);
        else passes++;
        repeat (20) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL halt_hold dut=%h exp=%h", dut_vec, exp_vec());
            else passes++;
        end
        MSTRT = 1'b1;
        tick();
        checks++;
        if (HALTED !== 1'b1 || T01 !== 1'b0) $display("FAIL halt_release_early halted=%b t01=%b", HALTED, T01);
        else passes++;
        tick();
        checks++;
        if (HALTED !== 1'b0 || T01 !== 1'b1) $display("FAIL halt_release halted=%b t01=%b", HALTED, T01);
        else passes++;
        run_to_hold(n);
        checks++;
        if (n !== CYCLE_LEN || HALTED !== 1'b1) $display("FAIL halt_one_cycle edges=%0d want=48 halted=%b", n, HALTED);
        else passes++;
        repeat (10) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL halt_mstrt_held dut=%h exp=%h", dut_vec, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_mstrt_in_run();
        int n;
        MSTRT = 1'b0;
        repeat (2) tick();
        MSTRT = 1'b1;
        repeat (2) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL mstrt_release dut=%h exp=%h", dut_vec, exp_vec());
            else passes++;
        end
        n = 0;
        while (m_mode != M_HOLD && n < 100) begin
            MSTRT = (m_pos < 40) ? 1'($urandom) : 1'b0;
            tick();
            n++;
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL mstrt_in_run pos=%0d dut=%h exp=%h", m_pos, dut_vec, exp_vec());
            else passes++;
        end
        repeat (10) tick();
        checks++;
        if (HALTED !== 1'b1 || dut_t !== 12'h000) $display("FAIL mstrt_discarded halted=%b t=%h", HALTED, dut_t);
        else passes++;
        MSTP = 1'b0;
        tick();
        checks++;
        if (HALTED !== 1'b0 || T01 !== 1'b1) $display("FAIL mstp_low_release halted=%b t01=%b", HALTED, T01);
        else passes++;
    endtask

    task automatic test_gojam();
        int n;
        advance_to(26);
        GOJAM = 1'b1;
        tick();
        GOJAM = 1'b0;
        checks++;
        if ({T01, T07, PHS2, PHS3, PHS4} !== 5'b10000 || dut_vec !== exp_vec())
            $display("FAIL gojam_pulse dut=%h exp=%h", dut_vec, exp_vec());
        else passes++;
        advance_to(10);
        GOJAM = 1'b1;
        repeat ($urandom_range(3, 8)) begin
            tick();
            checks++;
            if ({T01, PHS2, PHS3, PHS4} !== 4'b1000 || dut_vec !== exp_vec())
                $display("FAIL gojam_held dut=%h exp=%h", dut_vec, exp_vec());
            else passes++;
        end
        GOJAM = 1'b0;
        tick();
        checks++;
        if (dut_vec !== exp_vec()) $display("FAIL gojam_after dut=%h exp=%h", dut_vec, exp_vec());
        else passes++;
        MSTP = 1'b1;
        run_to_hold(n);
        repeat (3) tick();
        GOJAM = 1'b1;
        tick();
        GOJAM = 1'b0;
        MSTP  = 1'b0;
        checks++;
        if (T01 !== 1'b1 || HALTED !== 1'b0) $display("FAIL gojam_hold t01=%b halted=%b", T01, HALTED);
        else passes++;
    endtask

    task automatic test_reset_mid();
        advance_to(33);
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({T09, T09_, PHS2} !== 3'b010 || dut_vec !== exp_vec())
            $display("FAIL reset_mid t09=%b t09_=%b phs2=%b dut=%h", T09, T09_, PHS2, dut_vec);
        else passes++;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (T01 !== 1'b1 || dut_vec !== exp_vec()) $display("FAIL reset_restart dut=%h exp=%h", dut_vec, exp_vec());
        else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            GOJAM = ($urandom % 64) == 0;
            if (($urandom % 16) == 0) MSTP = ~MSTP;
            if (($urandom % 8) == 0)  MSTRT = ~MSTRT;
            if (($urandom % 700) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                checks++;
                if (dut_vec !== exp_vec()) $display("FAIL random_reset i=%0d dut=%h exp=%h", i, dut_vec, exp_vec());
                else passes++;
                tick();
                rst = 1'b0;
            end
            tick();
            checks++;
            if (dut_vec !== exp_vec())
                $display("FAIL random i=%0d mode=%0d pos=%0d dut=%h exp=%h", i, m_mode, m_pos, dut_vec, exp_vec());
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_first_cycle();
        test_free_run();
        test_halt();
        test_mstrt_in_run();
        test_gojam();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
